pipe_decoder: RTL and testbench

PIPE_DECODER -- requirements
Module: pipe_decoder

---
 rtl/pipe_decoder.sv | 247 ++++++++++++++++++++++++
 tb/tb_pipe_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_decoder
// Description : Registered MIPS decode stage with valid/ready handshake,
//               load-use stall and flush. Define PIPE_DECODER_EXT_ALU_EN to
//               add R-type AND/OR/XOR/NOR.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd,
    output logic [4:0]      rt,
    output logic [4:0]      rs,
    output logic [2:0]      op,
    output logic [1:0]      pcSrc,
    output logic [1:0]      regDIn,
    output logic [1:0]      regWAddr,
    output logic            regWe,
    output logic            dmWe,
    output logic            aluBSrc,
    output logic [25:0]     jAddr,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam logic [5:0] c_opc_rtype = 6'h00;
    localparam logic [5:0] c_opc_j     = 6'h02;
    localparam logic [5:0] c_opc_jal   = 6'h03;
    localparam logic [5:0] c_opc_bne   = 6'h05;
    localparam logic [5:0] c_opc_addi  = 6'h08;
    localparam logic [5:0] c_opc_xori  = 6'h0e;
    localparam logic [5:0] c_opc_lw    = 6'h23;
    localparam logic [5:0] c_opc_sw    = 6'h2b;

    localparam logic [5:0] c_fn_jr     = 6'h08;
    localparam logic [5:0] c_fn_add    = 6'h20;
    localparam logic [5:0] c_fn_sub    = 6'h22;
    localparam logic [5:0] c_fn_slt    = 6'h2a;
`ifdef PIPE_DECODER_EXT_ALU_EN
    localparam logic [5:0] c_fn_and    = 6'h24;
    localparam logic [5:0] c_fn_or     = 6'h25;
    localparam logic [5:0] c_fn_xor    = 6'h26;
    localparam logic [5:0] c_fn_nor    = 6'h27;
`endif

    localparam logic [2:0] c_op_add    = 3'd0;
    localparam logic [2:0] c_op_sub    = 3'd1;
    localparam logic [2:0] c_op_xor    = 3'd2;
    localparam logic [2:0] c_op_slt    = 3'd3;
`ifdef PIPE_DECODER_EXT_ALU_EN
    localparam logic [2:0] c_op_and    = 3'd4;
    localparam logic [2:0] c_op_nor    = 3'd6;
    localparam logic [2:0] c_op_or     = 3'd7;
`endif

    localparam logic [1:0] c_pc_inc4   = 2'd0;
    localparam logic [1:0] c_pc_j      = 2'd1;
    localparam logic [1:0] c_pc_jr     = 2'd2;
    localparam logic [1:0] c_pc_bne    = 2'd3;

    localparam logic [1:0] c_din_alu   = 2'd0;
    localparam logic [1:0] c_din_dm    = 2'd1;
    localparam logic [1:0] c_din_jal   = 2'd2;

    localparam logic [1:0] c_wa_rd     = 2'd0;
    localparam logic [1:0] c_wa_rt     = 2'd1;
    localparam logic [1:0] c_wa_r31    = 2'd2;

    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    logic [2:0]      w_op;
    logic [1:0]      w_pcsrc;
    logic [1:0]      w_regdin;
    logic [1:0]      w_regwaddr;
    logic            w_regwe;
    logic            w_dmwe;
    logic            w_alubsrc;
    logic            w_illegal;
    logic            w_reads_rt;
    logic            w_hazard;
    logic            w_accept;
    logic [XLEN-1:0] w_imm;

    logic            r_out_valid;
    logic            r_is_lw;
    logic [4:0]      r_rd;
    logic [4:0]      r_rt;
    logic [4:0]      r_rs;
    logic [2:0]      r_op;
    logic [1:0]      r_pcsrc;
    logic [1:0]      r_regdin;
    logic [1:0]      r_regwaddr;
    logic            r_regwe;
    logic            r_dmwe;
    logic            r_alubsrc;
    logic [25:0]     r_jaddr;
    logic [XLEN-1:0] r_imm;
    logic            r_illegal;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];

    generate
        if (XLEN == 16) begin : g_imm_native
            assign w_imm = instr[15:0];
        end else begin : g_imm_sext
            assign w_imm = {{(XLEN-16){instr[15]}}, instr[15:0]};
        end
    endgenerate

    always_comb begin
        w_op       = c_op_add;
        w_pcsrc    = c_pc_inc4;
        w_regdin   = c_din_alu;
        w_regwaddr = c_wa_rd;
        w_regwe    = 1'b0;
        w_dmwe     = 1'b0;
        w_alubsrc  = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            c_opc_lw: begin
                w_regwe    = 1'b1;
                w_alubsrc  = 1'b1;
                w_regdin   = c_din_dm;
                w_regwaddr = c_wa_rt;
            end
            c_opc_sw: begin
                w_dmwe    = 1'b1;
                w_alubsrc = 1'b1;
            end
            c_opc_j: begin
                w_pcsrc = c_pc_j;
            end
            c_opc_jal: begin
                w_pcsrc    = c_pc_j;
                w_regwe    = 1'b1;
                w_regwaddr = c_wa_r31;
                w_regdin   = c_din_jal;
            end
            c_opc_bne: begin
                w_op    = c_op_sub;
                w_pcsrc = c_pc_bne;
            end
            c_opc_addi, c_opc_xori: begin
                w_regwe    = 1'b1;
                w_alubsrc  = 1'b1;
                w_regwaddr = c_wa_rt;
                w_op       = (w_opcode == c_opc_xori) ? c_op_xor : c_op_add;
            end
            c_opc_rtype: begin
                case (w_funct)
                    c_fn_add: w_regwe = 1'b1;
                    c_fn_sub: begin w_regwe = 1'b1; w_op = c_op_sub; end
                    c_fn_slt: begin w_regwe = 1'b1; w_op = c_op_slt; end
                    c_fn_jr:  w_pcsrc = c_pc_jr;
`ifdef PIPE_DECODER_EXT_ALU_EN
                    c_fn_and: begin w_regwe = 1'b1; w_op = c_op_and; end
                    c_fn_or:  begin w_regwe = 1'b1; w_op = c_op_or;  end
                    c_fn_xor: begin w_regwe = 1'b1; w_op = c_op_xor; end
                    c_fn_nor: begin w_regwe = 1'b1; w_op = c_op_nor; end
`endif
                    default:  w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Load-use: a held LW writing rt must reach the register file before a
    // consumer of that register may enter; $zero never creates a dependency.
    assign w_reads_rt = (w_opcode == c_opc_rtype) || (w_opcode == c_opc_sw) ||
                        (w_opcode == c_opc_bne);
    assign w_hazard   = r_out_valid && r_is_lw && (r_rt != 5'd0) && in_valid &&
                        ((instr[25:21] == r_rt) ||
                         (w_reads_rt && (instr[20:16] == r_rt)));
    assign in_ready   = !reset && (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_is_lw     <= 1'b0;
            r_rd        <= '0;
            r_rt        <= '0;
            r_rs        <= '0;
            r_op        <= '0;
            r_pcsrc     <= '0;
            r_regdin    <= '0;
            r_regwaddr  <= '0;
            r_regwe     <= 1'b0;
            r_dmwe      <= 1'b0;
            r_alubsrc   <= 1'b0;
            r_jaddr     <= '0;
            r_imm       <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_is_lw     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_is_lw     <= (w_opcode == c_opc_lw);
            r_rd        <= instr[15:11];
            r_rt        <= instr[20:16];
            r_rs        <= instr[25:21];
            r_op        <= w_op;
            r_pcsrc     <= w_pcsrc;
            r_regdin    <= w_regdin;
            r_regwaddr  <= w_regwaddr;
            r_regwe     <= w_regwe;
            r_dmwe      <= w_dmwe;
            r_alubsrc   <= w_alubsrc;
            r_jaddr     <= instr[25:0];
            r_imm       <= w_imm;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_is_lw     <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign rd        = r_rd;
    assign rt        = r_rt;
    assign rs        = r_rs;
    assign op        = r_op;
    assign pcSrc     = r_pcsrc;
    assign regDIn    = r_regdin;
    assign regWAddr  = r_regwaddr;
    assign regWe     = r_regwe;
    assign dmWe      = r_dmwe;
    assign aluBSrc   = r_alubsrc;
    assign jAddr     = r_jaddr;
    assign imm       = r_imm;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_decoder
// Description : Directed and random stimulus for pipe_decoder against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_decoder;

    localparam int XLEN = 32;
`ifdef PIPE_DECODER_EXT_ALU_EN
    localparam bit c_EXT = 1'b1;
`else
    localparam bit c_EXT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     instr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [4:0]      rd, rt, rs;
    logic [2:0]      op;
    logic [1:0]      pcSrc, regDIn, regWAddr;
    logic            regWe, dmWe, aluBSrc;
    logic [25:0]     jAddr;
    logic [XLEN-1:0] imm;
    logic            illegal;

    pipe_decoder #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .rt(rt), .rs(rs), .op(op), .pcSrc(pcSrc),
        .regDIn(regDIn), .regWAddr(regWAddr), .regWe(regWe),
        .dmWe(dmWe), .aluBSrc(aluBSrc), .jAddr(jAddr), .imm(imm),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] pcsrc;
        logic [1:0] regdin;
        logic [1:0] regwaddr;
        logic       regwe;
        logic       dmwe;
        logic       alubsrc;
        logic       illegal;
    } ctl_t;

    int          n_total = 0;
    int          n_bad   = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_ins   = '0;
    ctl_t        m_ctl   = '0;
    logic        last_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected control bundle straight from the instruction-set table.
    function automatic ctl_t dec(input logic [31:0] w);
        ctl_t c;
        c = '0;
        case (w[31:26])
            6'h23: begin c.regwe = 1; c.alubsrc = 1; c.regdin = 1; c.regwaddr = 1; end
            6'h2b: begin c.dmwe = 1; c.alubsrc = 1; end
            6'h02: c.pcsrc = 1;
            6'h03: begin c.pcsrc = 1; c.regwe = 1; c.regwaddr = 2; c.regdin = 2; end
            6'h05: begin c.op = 1; c.pcsrc = 3; end
            6'h08: begin c.regwe = 1; c.alubsrc = 1; c.regwaddr = 1; end
            6'h0e: begin c.regwe = 1; c.alubsrc = 1; c.regwaddr = 1; c.op = 2; end
            6'h00: begin
                case (w[5:0])
                    6'h20: c.regwe = 1;
                    6'h22: begin c.regwe = 1; c.op = 1; end
                    6'h2a: begin c.regwe = 1; c.op = 3; end
                    6'h08: c.pcsrc = 2;
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        if (c_EXT) begin
                            c.regwe = 1;
                            c.op = (w[5:0] == 6'h24) ? 3'd4 : (w[5:0] == 6'h25) ? 3'd7 :
                                   (w[5:0] == 6'h26) ? 3'd2 : 3'd6;
                        end else begin
                            c.illegal = 1;
                        end
                    end
                    default: c.illegal = 1;
                endcase
            end
            default: c.illegal = 1;
        endcase
        return c;
    endfunction

    task automatic check_outputs();
        logic [63:0] exp_imm;
        exp_imm = 64'($signed(m_ins[15:0]));
        chk("out_valid", out_valid, m_valid);
        chk("illegal",   illegal,   m_ctl.illegal);
        chk("regWe",     regWe,     m_ctl.regwe);
        chk("dmWe",      dmWe,      m_ctl.dmwe);
        chk("aluBSrc",   aluBSrc,   m_ctl.alubsrc);
        chk("op",        op,        m_ctl.op);
        chk("pcSrc",     pcSrc,     m_ctl.pcsrc);
        chk("regDIn",    regDIn,    m_ctl.regdin);
        chk("regWAddr",  regWAddr,  m_ctl.regwaddr);
        chk("rd",        rd,        m_ins[15:11]);
        chk("rt",        rt,        m_ins[20:16]);
        chk("rs",        rs,        m_ins[25:21]);
        chk("jAddr",     jAddr,     m_ins[25:0]);
        chk("imm",       imm,       exp_imm[XLEN-1:0]);
    endtask

    // One clock: check held outputs, apply inputs, check in_ready, advance model.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] ins, input logic ordy);
        logic       hz;
        logic       reads_rt;
        logic       exp_rdy;
        logic [4:0] x;
        @(negedge clk);
        check_outputs();
        reset = rst; flush = fl; in_valid = iv; instr = ins; out_ready = ordy;
        #1;
        x        = m_ins[20:16];
        reads_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2b) || (ins[31:26] == 6'h05);
        hz       = m_valid && (m_ins[31:26] == 6'h23) && (x != 0) && iv &&
                   ((ins[25:21] == x) || (reads_rt && ins[20:16] == x));
        exp_rdy  = !rst && (!m_valid || ordy) && !hz && !fl;
        chk("in_ready", in_ready, exp_rdy);
        last_rdy = in_ready;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_ins = '0; m_ctl = '0;
        end else if (fl) begin
            m_valid = 0; m_ctl.illegal = 0;
        end else if (iv && exp_rdy) begin
            m_valid = 1; m_ins = ins; m_ctl = dec(ins);
        end else if (ordy) begin
            m_valid = 0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] opcs [9];
        logic [5:0] fns  [9];
        logic [31:0] w;
        opcs = '{6'h00, 6'h23, 6'h2b, 6'h02, 6'h03, 6'h05, 6'h08, 6'h0e, 6'h3f};
        fns  = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h24, 6'h25, 6'h26, 6'h27, 6'h01};
        w = $urandom;
        w[31:26] = opcs[$urandom_range(0, 8)];
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 8)];
        return w;
    endfunction

    initial begin
        int lows;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);

        // ADDI $t0,$zero,-1
        step(0, 0, 1, 32'h2008FFFF, 1);
        #2;
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_regWAddr", regWAddr, 2'd1);

        // LW $8,0($0) then ADD $9,$8,$8
        step(0, 0, 1, 32'h8C080000, 1);
        lows = 0;
        step(0, 0, 1, 32'h01084820, 1);
        if (!last_rdy) lows++;
        #2;
        chk("hz_bubble", out_valid, 1'b0);
        step(0, 0, 1, 32'h01084820, 1);
        if (!last_rdy) lows++;
        chk("hz_stall_cycles", 64'(lows), 64'd1);
        #2;
        chk("hz_add_rd", rd, 5'd9);
        step(0, 0, 0, 32'h0, 1);

        // SW under backpressure
        step(0, 0, 1, 32'hAC0A0004, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 32'h2008FFFF, 0);
            chk("bp_in_ready", last_rdy, 1'b0);
            #2;
            chk("bp_dmWe", dmWe, 1'b1);
        end
        step(0, 0, 0, 32'h0, 1);

        // flush while JAL held
        step(0, 0, 1, 32'h0C000010, 0);
        step(0, 1, 1, 32'h2008FFFF, 0);
        chk("flush_in_ready", last_rdy, 1'b0);
        #2;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_illegal", illegal, 1'b0);
        step(0, 0, 0, 32'h0, 1);

        // funct 0x25
        step(0, 0, 1, 32'h00000025, 1);
        #2;
        chk("or_illegal", illegal, !c_EXT);
        chk("or_op", op, c_EXT ? 3'd7 : 3'd0);
        chk("or_regWe", regWe, c_EXT);

        // reset with an entry held
        step(0, 0, 1, 32'h2008FFFF, 0);
        step(1, 0, 1, 32'h2008FFFF, 0);
        chk("rst_in_ready", last_rdy, 1'b0);
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_regWe", regWe, 1'b0);
        step(0, 0, 0, 32'h0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 2) != 0));
        end
        step(0, 0, 0, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
